instruction_fetch_unit: RTL

//   Fetches 16-bit instruction words from 8-bit byte-wide memory over a request/ack handshake.

---
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetches 16-bit instruction words as two bytes from a byte-wide memory,
// assembles them into the instruction register, and holds the result for
// the decoder with a valid/ready handshake. Owns the program counter.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter bit          LOW_FIRST = 1'b1
) (
    input  logic        Clock,
    input  logic        rst,
    input  logic        en,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [15:0] ir_q,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] pc_q,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH_A = 2'd1;
    localparam logic [1:0] ST_FETCH_B = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [1:0]  w_nextState;
    logic        w_takeA;
    logic        w_takeB;

    // A byte is only accepted while requesting it, and a redirect discards it.
    assign w_takeA = (r_state == ST_FETCH_A) && mem_ack && !pc_load;
    assign w_takeB = (r_state == ST_FETCH_B) && mem_ack && !pc_load;

    assign mem_rd   = (r_state == ST_FETCH_A) || (r_state == ST_FETCH_B);
    assign ir_valid = (r_state == ST_HOLD);
    assign busy     = (r_state != ST_IDLE);
    assign mem_addr = r_pc;
    assign pc_q     = r_pc;
    assign ir_q     = r_ir;

    // Next-state decode; a PC redirect overrides every state's normal exit.
    always_comb begin
        w_nextState = r_state;
        if (pc_load) begin
            w_nextState = en ? ST_FETCH_A : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (en)       w_nextState = ST_FETCH_A;
                ST_FETCH_A: if (mem_ack)  w_nextState = ST_FETCH_B;
                ST_FETCH_B: if (mem_ack)  w_nextState = ST_HOLD;
                ST_HOLD:    if (ir_ready) w_nextState = en ? ST_FETCH_A : ST_IDLE;
                default:                  w_nextState = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Program counter: redirect wins, otherwise advance once per accepted byte (wraps mod 2^16).
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (pc_load) begin
            r_pc <= pc_load_val;
        end else if (w_takeA || w_takeB) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    // Instruction register: each half is written only on its own accepted byte.
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_ir <= 16'h0000;
        end else begin
            if (w_takeA) begin
                if (LOW_FIRST) begin
                    r_ir[7:0] <= mem_data;
                end else begin
                    r_ir[15:8] <= mem_data;
                end
            end
            if (w_takeB) begin
                if (LOW_FIRST) begin
                    r_ir[15:8] <= mem_data;
                end else begin
                    r_ir[7:0] <= mem_data;
                end
            end
        end
    end

endmodule
